// File: rtl/spw_rx_queue_8x9_if.sv
// ---------------------------------------------------------------------------
// spw_rx_queue_8x9_if
//
// Groups the character-input side and the Wishbone read side of the
// SpaceWire receive queue into one bundle.
//
//   master : drives nchar, lchar, char_i, stb_i; observes ack_o, dat_o,
//            full_o, empty_o (the link receiver + bus host side).
//   slave  : the queue itself.
//
// Signals:
//   nchar    char_i holds a data character this cycle
//   lchar    char_i holds a control character (code in char_i[1:0])
//   char_i   8-bit character payload
//   stb_i    Wishbone read strobe
//   ack_o    Wishbone acknowledge (registered), dat_o valid while high
//   dat_o    head entry {lchar flag, char}
//   full_o   all 8 slots occupied
//   empty_o  no slot occupied
// ---------------------------------------------------------------------------
interface spw_rx_queue_8x9_if;
  logic       nchar;
  logic       lchar;
  logic [7:0] char_i;
  logic       stb_i;
  logic       ack_o;
  logic [8:0] dat_o;
  logic       full_o;
  logic       empty_o;

  modport master (
    output nchar,
    output lchar,
    output char_i,
    output stb_i,
    input  ack_o,
    input  dat_o,
    input  full_o,
    input  empty_o
  );

  modport slave (
    input  nchar,
    input  lchar,
    input  char_i,
    input  stb_i,
    output ack_o,
    output dat_o,
    output full_o,
    output empty_o
  );
endinterface

// File: rtl/spw_rx_queue_8x9.sv
// ---------------------------------------------------------------------------
// spw_rx_queue_8x9
//
// 8-entry x 9-bit receive FIFO for SpaceWire characters. Data characters
// (nchar) and EOP/EEP control characters (lchar codes 2'b01 / 2'b10) are
// stored; FCT (2'b00) and ESC (2'b11) are discarded. Each entry is
// {lchar flag, char}. The read side is a Wishbone B4 pipelined slave: ack_o
// follows stb_i by one cycle and dat_o always shows the head entry.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   bus          spw_rx_queue_8x9_if.slave (char input + Wishbone read)
//   occupied_tb  per-slot valid bits (debug)
//   rp_tb        read pointer (debug)
//   wp_tb        write pointer (debug)
//   we_tb        internal write enable (debug)
//   overrun_o    sticky dropped-character flag, only with QUEUE_OVERRUN_EN
//
// Optional feature macro: QUEUE_OVERRUN_EN
//   When defined, overrun_o is added. It is set whenever a storable
//   character arrives while the queue is full and nothing is popped in the
//   same cycle, and it is cleared only by reset.
// ---------------------------------------------------------------------------
module spw_rx_queue_8x9 (
  input  logic                     clk,
  input  logic                     reset,
  spw_rx_queue_8x9_if.slave        bus,
  output logic [7:0]               occupied_tb,
  output logic [2:0]               rp_tb,
  output logic [2:0]               wp_tb,
  output logic                     we_tb
`ifdef QUEUE_OVERRUN_EN
  ,
  output logic                     overrun_o
`endif
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [8:0] mem [0:7];
  logic [7:0] occupied_reg;
  logic [2:0] rp_reg;
  logic [2:0] wp_reg;
  logic       ack_reg;

  // -------------------------------------------------------------------------
  // Character filter and write/pop qualification
  // -------------------------------------------------------------------------
  logic       lchar_storable;
  logic       valid;
  logic [8:0] word;
  logic       full;
  logic       empty;
  logic       pop;
  logic       we;

  // Only EOP (2'b01) and EEP (2'b10) control codes are kept.
  assign lchar_storable = bus.lchar &
                          ((bus.char_i[1:0] == 2'b01) || (bus.char_i[1:0] == 2'b10));
  assign valid          = bus.nchar | lchar_storable;

  // nchar wins when both strobes are high, so the flag is simply ~nchar;
  // when nchar is low a valid character can only be an lchar.
  assign word  = {~bus.nchar, bus.char_i};

  assign full  = &occupied_reg;
  assign empty = ~|occupied_reg;

  // A pop happens on the edge that ends an ack cycle, so the head stays
  // stable on dat_o for the whole time ack_o is high.
  assign pop   = ack_reg & ~empty;

  // A full queue still accepts a character in the cycle a slot is freed.
  assign we    = valid & (~full | pop);

  // -------------------------------------------------------------------------
  // Per-slot occupancy. Set takes precedence over clear so that a
  // simultaneous pop and write on the same slot (full queue, rp == wp)
  // leaves the slot occupied.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      logic set_slot;
      logic clr_slot;
      logic slot_reg;

      assign set_slot = we  && (wp_reg == 3'(gi));
      assign clr_slot = pop && (rp_reg == 3'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          slot_reg <= 1'b0;
        end else if (set_slot) begin
          slot_reg <= 1'b1;
        end else if (clr_slot) begin
          slot_reg <= 1'b0;
        end
      end

      assign occupied_reg[gi] = slot_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Pointers and acknowledge. Pointers are 3 bits and wrap 7 -> 0 naturally.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp_reg  <= 3'd0;
      wp_reg  <= 3'd0;
      ack_reg <= 1'b0;
    end else begin
      ack_reg <= bus.stb_i;
      if (pop) begin
        rp_reg <= rp_reg + 3'd1;
      end
      if (we) begin
        wp_reg <= wp_reg + 3'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage. Contents survive reset; only occupancy says what is valid.
  // The head is read combinationally so dat_o tracks rp without latency.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wp_reg] <= word;
    end
  end

  assign bus.dat_o   = mem[rp_reg];
  assign bus.ack_o   = ack_reg;
  assign bus.full_o  = full;
  assign bus.empty_o = empty;

  // -------------------------------------------------------------------------
  // Optional sticky overrun flag
  // -------------------------------------------------------------------------
`ifdef QUEUE_OVERRUN_EN
  logic overrun_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else if (valid && full && !pop) begin
      overrun_reg <= 1'b1;
    end
  end

  assign overrun_o = overrun_reg;
`endif

  // -------------------------------------------------------------------------
  // Debug visibility
  // -------------------------------------------------------------------------
  assign occupied_tb = occupied_reg;
  assign rp_tb       = rp_reg;
  assign wp_tb       = wp_reg;
  assign we_tb       = we;

endmodule

// File: tb/tb_spw_rx_queue_8x9.sv
// ---------------------------------------------------------------------------
// tb_spw_rx_queue_8x9
//
// Self-checking bench for spw_rx_queue_8x9. The reference model is a plain
// queue of stored words plus running read/write counts; per-slot occupancy
// is derived from the head position and queue length.
// ---------------------------------------------------------------------------
module tb_spw_rx_queue_8x9;

  logic       clk;
  logic       reset;
  logic [7:0] occupied_tb;
  logic [2:0] rp_tb;
  logic [2:0] wp_tb;
  logic       we_tb;
`ifdef QUEUE_OVERRUN_EN
  logic       overrun_o;
`endif

  spw_rx_queue_8x9_if bus_if ();

  spw_rx_queue_8x9 dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .occupied_tb (occupied_tb),
    .rp_tb       (rp_tb),
    .wp_tb       (wp_tb),
    .we_tb       (we_tb)
`ifdef QUEUE_OVERRUN_EN
    ,
    .overrun_o   (overrun_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [8:0] q [$];
  int         rp_m;
  int         wp_m;
  logic       ack_m;
  logic       ovr_m;

  int errors;
  int checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_occ();
    logic [7:0] o;
    o = 8'h00;
    for (int i = 0; i < q.size(); i++) o[(rp_m + i) % 8] = 1'b1;
    return o;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "/occ"},   {24'd0, occupied_tb},      {24'd0, exp_occ()});
    check({tag, "/rp"},    {29'd0, rp_tb},            rp_m);
    check({tag, "/wp"},    {29'd0, wp_tb},            wp_m);
    check({tag, "/ack"},   {31'd0, bus_if.ack_o},     {31'd0, ack_m});
    check({tag, "/full"},  {31'd0, bus_if.full_o},    (q.size() == 8) ? 1 : 0);
    check({tag, "/empty"}, {31'd0, bus_if.empty_o},   (q.size() == 0) ? 1 : 0);
`ifdef QUEUE_OVERRUN_EN
    check({tag, "/ovr"},   {31'd0, overrun_o},        {31'd0, ovr_m});
`endif
  endtask

  // One clock cycle: drive inputs, check combinational outputs, take the
  // edge, advance the model and compare the registered state.
  task automatic step(input logic n, input logic l, input logic [7:0] c,
                      input logic s, input string tag);
    logic       valid_m;
    logic       pop_m;
    logic       we_m;
    logic [8:0] word_m;
    bus_if.nchar  = n;
    bus_if.lchar  = l;
    bus_if.char_i = c;
    bus_if.stb_i  = s;
    #1;
    valid_m = n | (l & ((c[1:0] == 2'b01) || (c[1:0] == 2'b10)));
    pop_m   = ack_m && (q.size() > 0);
    we_m    = valid_m && ((q.size() < 8) || pop_m);
    word_m  = n ? {1'b0, c} : {1'b1, c};
    check({tag, "/we"}, {31'd0, we_tb}, {31'd0, we_m});
    if (ack_m && (q.size() > 0)) check({tag, "/dat"}, {23'd0, bus_if.dat_o}, {23'd0, q[0]});
    @(posedge clk);
    #1;
    if (valid_m && (q.size() == 8) && !pop_m) ovr_m = 1'b1;
    if (pop_m) begin
      void'(q.pop_front());
      rp_m = (rp_m + 1) % 8;
    end
    if (we_m) begin
      q.push_back(word_m);
      wp_m = (wp_m + 1) % 8;
    end
    ack_m = s;
    check_state(tag);
  endtask

  // Reset asserted and released between clock edges; state must clear
  // immediately, not at the next edge.
  task automatic do_reset(input string tag);
    #3;
    bus_if.nchar  = 1'b0;
    bus_if.lchar  = 1'b0;
    bus_if.char_i = 8'h00;
    bus_if.stb_i  = 1'b0;
    reset = 1'b1;
    #1;
    q.delete();
    rp_m  = 0;
    wp_m  = 0;
    ack_m = 1'b0;
    ovr_m = 1'b0;
    check_state({tag, "/async"});
    #1;
    reset = 1'b0;
    #1;
    check_state({tag, "/release"});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    q.delete();
    rp_m  = 0;
    wp_m  = 0;
    ack_m = 1'b0;
    ovr_m = 1'b0;
    bus_if.nchar  = 1'b0;
    bus_if.lchar  = 1'b0;
    bus_if.char_i = 8'h00;
    bus_if.stb_i  = 1'b0;
    reset = 1'b1;

    // Power-on reset
    #12;
    check_state("por");
    @(negedge clk);
    reset = 1'b0;

    // Character filter
    step(1'b0, 1'b1, 8'hFF, 1'b0, "filt_esc");
    step(1'b0, 1'b1, 8'h00, 1'b0, "filt_fct");
    step(1'b0, 1'b1, 8'h02, 1'b0, "filt_eep");
    step(1'b0, 1'b1, 8'h01, 1'b0, "filt_eop");
    step(1'b1, 1'b0, 8'h3C, 1'b0, "filt_n");
    step(1'b1, 1'b1, 8'h03, 1'b1, "filt_both");

    // Asynchronous reset with a partially full queue and ack high
    check("pre_rst/wp", {29'd0, wp_tb}, 32'd4);
    do_reset("rst_mid");

    // Fill from reset
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'(k * 17 + 3), 1'b0, "fill");
    check("fill/occ_ff", {24'd0, occupied_tb}, 32'hFF);
    check("fill/full",   {31'd0, bus_if.full_o}, 32'd1);
    step(1'b1, 1'b0, 8'hEE, 1'b0, "fill_9th");

    // Drain with a pause
    step(1'b0, 1'b0, 8'h00, 1'b1, "drain_ack");
    step(1'b0, 1'b0, 8'h00, 1'b1, "drain_1");
    step(1'b0, 1'b0, 8'h00, 1'b1, "drain_2");
    step(1'b0, 1'b0, 8'h00, 1'b0, "drain_pause_a");
    step(1'b0, 1'b0, 8'h00, 1'b0, "drain_pause_b");
    check("drain/rp3", {29'd0, rp_tb}, 32'd3);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 8'h00, 1'b1, "drain_rest");
    check("drain/empty", {31'd0, bus_if.empty_o}, 32'd1);
    check("drain/rp0",   {29'd0, rp_tb}, 32'd0);

    // Concurrent read/write on a full queue
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 8'h55, 1'b0, "conc_fill");
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 8'hAA, 1'b1, "conc_rw");
    check("conc/dat_aa", {23'd0, bus_if.dat_o}, 32'h0AA);
    step(1'b0, 1'b0, 8'h00, 1'b0, "conc_stop");
    check("conc/occ_fe", {24'd0, occupied_tb}, 32'hFE);
    check("conc/rp1",    {29'd0, rp_tb}, 32'd1);

`ifdef QUEUE_OVERRUN_EN
    // Overrun: push into a full queue with no reads
    do_reset("ovr_rst");
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 8'(k), 1'b0, "ovr_push");
    check("ovr/set", {31'd0, overrun_o}, 32'd1);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 8'h00, 1'b1, "ovr_hold");
    check("ovr/sticky", {31'd0, overrun_o}, 32'd1);
`endif

    // Randomized traffic against the model
    do_reset("rand_rst");
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
           8'($urandom), ($urandom_range(0, 2) != 0), "rand");
      if ((k % 137) == 136) do_reset("rand_mid_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
